s4ga_cfg_streamer: RTL

S4GA_CFG_STREAMER -- requirements
Module: s4ga_cfg_streamer

---
 rtl/s4ga_pkg.sv | 30 +++
 rtl/s4ga_seg_ser.sv | 56 +++++
 rtl/s4ga_cfg_streamer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/s4ga_pkg.sv
// Shared s4ga constants, FSM states and the packed per-LUT configuration layout.
package s4ga_pkg;

    localparam int S4GA_N    = 64;
    localparam int S4GA_K    = 5;
    localparam int S4GA_SI_W = 4;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    localparam int N_W       = $clog2(S4GA_N);
    localparam int MASK_W    = 2 ** S4GA_K;
    localparam int IDX_SEGS  = (N_W + S4GA_SI_W - 1) / S4GA_SI_W;
    localparam int MASK_SEGS = (MASK_W + S4GA_SI_W - 1) / S4GA_SI_W;
    localparam int LUT_SEGS  = S4GA_K * IDX_SEGS + MASK_SEGS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM
    } cfg_state_t;

    // idx[0] occupies the most significant bits, mask the least significant.
    typedef struct packed {
        logic [0:S4GA_K-1][N_W-1:0] idx;
        logic [MASK_W-1:0]          mask;
    } lut_cfg_t;

endpackage

// File: rtl/s4ga_seg_ser.sv
// Field serializer: holds one left-aligned, zero-padded field and presents it
// SI_W bits at a time, MSB segment first.
module s4ga_seg_ser
    import s4ga_pkg::*;
#(
    parameter int SI_W  = 4,
    parameter int SEGS  = 8,
    parameter int CNT_W = $clog2(SEGS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 load,
    input  logic [SEGS*SI_W-1:0] ld_data,
    input  logic [CNT_W-1:0]     ld_segs,
    input  logic                 shift,
    output logic [SI_W-1:0]      seg,
    output logic                 last,
    output logic                 penult
);

    logic [SEGS*SI_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    // Shift register and remaining-segment count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    // Clear beats load beats shift; cnt_q counts segments left after the current one.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clr) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (load) begin
            sr_d  = ld_data;
            cnt_d = ld_segs - CNT_W'(1);
        end else if (shift) begin
            sr_d = sr_q << SI_W;
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign seg    = sr_q[SEGS*SI_W-1 -: SI_W];
    assign last   = (cnt_q == '0);
    assign penult = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/s4ga_cfg_streamer.sv
// Streams the LUT configuration table into the s4ga fabric: a fabric reset of
// N cycles, then one SI_W-bit segment per cycle for LUT 0..N-1, repeating
// while run is held. Passes always complete so the fabric LUT counter ends at 0.
module s4ga_cfg_streamer
    import s4ga_pkg::*;
#(
    parameter int N    = S4GA_N,
    parameter int K    = S4GA_K,
    parameter int SI_W = S4GA_SI_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run,
    input  logic                          cfg_we,
    input  logic [$clog2(N)-1:0]          cfg_addr,
    input  logic [K*$clog2(N)+2**K-1:0]   cfg_wdata,
    output logic [SI_W-1:0]               so_si,
    output logic                          so_rst,
    output logic                          busy,
    output logic [$clog2(N)-1:0]          lut_n,
    output logic                          pass_done
);

    localparam int NW    = $clog2(N);
    localparam int MW    = 2 ** K;
    localparam int CW    = K * NW + MW;
    localparam int ISEGS = ceil_div(NW, SI_W);
    localparam int MSEGS = ceil_div(MW, SI_W);
    localparam int PSEGS = (ISEGS > MSEGS) ? ISEGS : MSEGS;
    localparam int PAD_W = PSEGS * SI_W;
    localparam int SCW   = $clog2(PSEGS + 1);
    localparam int FW    = $clog2(K + 1);

    // Field f<K is idx[f]; f==K is the mask. Result is zero-extended to a whole
    // number of segments and left-aligned in the serializer width.
    function automatic logic [PAD_W-1:0] field_bits(input logic [CW-1:0] w,
                                                    input logic [FW-1:0] f);
        logic [PAD_W-1:0] r;
        if (f == FW'(K)) r = PAD_W'(w[MW-1:0]) << (PAD_W - MSEGS * SI_W);
        else             r = PAD_W'(w[MW + (K - 1 - int'(f)) * NW +: NW]) << (PAD_W - ISEGS * SI_W);
        return r;
    endfunction

    logic [CW-1:0] cfg_tbl [N];

    cfg_state_t    state_q, state_d;
    logic [NW-1:0] clr_cnt_q, clr_cnt_d;
    logic [NW-1:0] lut_q, lut_d;
    logic [FW-1:0] fld_q, fld_d;
    logic [CW-1:0] hold_q, hold_d;
    logic          so_rst_q, so_rst_d;
    logic          busy_q, busy_d;
    logic          pass_done_q, pass_done_d;

    logic             ser_clr, ser_load, ser_shift;
    logic             ser_last, ser_penult;
    logic [SI_W-1:0]  ser_seg;
    logic [CW-1:0]    ld_src;
    logic [PAD_W-1:0] ld_data;
    logic [SCW-1:0]   ld_segs;

    // Write-only config table; not reset, writable in every state.
    always_ff @(posedge clk) begin
        if (cfg_we) cfg_tbl[cfg_addr] <= cfg_wdata;
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            clr_cnt_q   <= '0;
            lut_q       <= '0;
            fld_q       <= '0;
            hold_q      <= '0;
            so_rst_q    <= 1'b1;
            busy_q      <= 1'b0;
            pass_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            lut_q       <= lut_d;
            fld_q       <= fld_d;
            hold_q      <= hold_d;
            so_rst_q    <= so_rst_d;
            busy_q      <= busy_d;
            pass_done_q <= pass_done_d;
        end
    end

    // Next state; the segment shown next cycle is loaded/shifted into the serializer now.
    // A LUT's entry is snapshotted into hold_q on its first segment so later
    // table writes cannot tear it.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        lut_d       = lut_q;
        fld_d       = fld_q;
        hold_d      = hold_q;
        so_rst_d    = so_rst_q;
        busy_d      = busy_q;
        pass_done_d = 1'b0;
        ser_clr     = 1'b0;
        ser_load    = 1'b0;
        ser_shift   = 1'b0;
        ld_src      = hold_q;
        unique case (state_q)
            ST_IDLE: begin
                so_rst_d = 1'b1;
                busy_d   = 1'b0;
                ser_clr  = 1'b1;
                lut_d    = '0;
                fld_d    = '0;
                if (run) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                    busy_d    = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == NW'(N - 1)) begin
                    state_d  = ST_STREAM;
                    so_rst_d = 1'b0;
                    lut_d    = '0;
                    fld_d    = '0;
                    hold_d   = cfg_tbl[0];
                    ld_src   = cfg_tbl[0];
                    ser_load = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + NW'(1);
                end
            end
            ST_STREAM: begin
                if (!ser_last) begin
                    ser_shift = 1'b1;
                    if (lut_q == NW'(N - 1) && fld_q == FW'(K) && ser_penult) pass_done_d = 1'b1;
                end else if (fld_q != FW'(K)) begin
                    fld_d    = fld_q + FW'(1);
                    ser_load = 1'b1;
                    if (fld_d == FW'(K) && lut_q == NW'(N - 1) && MSEGS == 1) pass_done_d = 1'b1;
                end else if (lut_q != NW'(N - 1)) begin
                    lut_d    = lut_q + NW'(1);
                    fld_d    = '0;
                    hold_d   = cfg_tbl[lut_d];
                    ld_src   = cfg_tbl[lut_d];
                    ser_load = 1'b1;
                end else if (run) begin
                    lut_d    = '0;
                    fld_d    = '0;
                    hold_d   = cfg_tbl[0];
                    ld_src   = cfg_tbl[0];
                    ser_load = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                    so_rst_d = 1'b1;
                    busy_d   = 1'b0;
                    ser_clr  = 1'b1;
                    lut_d    = '0;
                    fld_d    = '0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                so_rst_d = 1'b1;
                busy_d   = 1'b0;
                ser_clr  = 1'b1;
            end
        endcase
        ld_data = field_bits(ld_src, fld_d);
        ld_segs = (fld_d == FW'(K)) ? SCW'(MSEGS) : SCW'(ISEGS);
    end

    s4ga_seg_ser #(
        .SI_W  (SI_W),
        .SEGS  (PSEGS),
        .CNT_W (SCW)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .clr     (ser_clr),
        .load    (ser_load),
        .ld_data (ld_data),
        .ld_segs (ld_segs),
        .shift   (ser_shift),
        .seg     (ser_seg),
        .last    (ser_last),
        .penult  (ser_penult)
    );

    assign so_si     = ser_seg;
    assign so_rst    = so_rst_q;
    assign busy      = busy_q;
    assign lut_n     = lut_q;
    assign pass_done = pass_done_q;

endmodule
